// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and SR/Cause field positions.
// Imported by cp0_unit and by the execute stage's exception-code generation.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt responder at the end of the M stage.
// Holds SR, Cause, EPC and PRId and serves mfc0, mtc0 and eret.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_1920
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [6:2]  ExcCodeIn,
  input  logic [7:2]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] epc_base;
  logic [31:0] epc_next;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_pend = sr_ie & (|(HWInt & sr_im));
  assign exc_pend = |ExcCodeIn;
  assign IntReq   = ~sr_exl & (int_pend | exc_pend);

  // A delay-slot instruction restarts at its branch, one word earlier (wraps modulo 2^32).
  assign epc_base = PC & ~32'd3;
  assign epc_next = BDIn ? epc_base - 32'd4 : epc_base;

  always_comb begin
    sr_word = '0;
    sr_word[SR_IM_LO +: 6] = sr_im;
    sr_word[SR_EXL]        = sr_exl;
    sr_word[SR_IE]         = sr_ie;
  end

  always_comb begin
    cause_word = '0;
    cause_word[CAUSE_BD]           = cause_bd;
    cause_word[CAUSE_IP_LO +: 6]   = cause_ip;
    cause_word[CAUSE_EXC_LO +: 5]  = cause_exc;
  end

  // Register block: a taken request cancels the M instruction, so its mtc0 is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BDIn;
        cause_exc <= int_pend ? EXC_INT : ExcCodeIn;
        epc       <= epc_next;
      end else begin
        if (WE) begin
          case (A2)
            REG_SR: begin
              sr_im  <= DIn[SR_IM_LO +: 6];
              sr_exl <= DIn[SR_EXL];
              sr_ie  <= DIn[SR_IE];
            end
            REG_EPC: epc <= DIn & ~32'd3;
            default: ;
          endcase
        end
        if (EXLClr) sr_exl <= 1'b0;
      end
    end
  end

  assign EPCOut = epc;

  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc;
      REG_PRID:  DOut = PRID;
      default:   DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expectations are queued with each stimulus step
// and popped against the live outputs before the next rising edge.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [6:2]  ExcCodeIn;
  logic [7:2]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  cp0_unit #(.PRID(32'h0000_1920)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .IntReq(IntReq), .EPCOut(EPCOut), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [4:0]  a1;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam int OUT_DOUT = 0;
  localparam int OUT_REQ  = 1;
  localparam int OUT_EPC  = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input string tag, input logic [4:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = OUT_DOUT; e.a1 = a; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_out(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.a1 = 5'd0; e.val = v;
    exp_q.push_back(e);
  endtask

  // Compare every queued expectation against the outputs of the current cycle.
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      A1 = e.a1;
      #1;
      case (e.sel)
        OUT_DOUT: chk(e.tag, DOut, e.val);
        OUT_REQ:  chk(e.tag, {31'd0, IntReq}, e.val);
        default:  chk(e.tag, EPCOut, e.val);
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    WE = 1'b0;
    EXLClr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    A2 = a; DIn = d; WE = 1'b1;
    step();
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; WE = 1'b0; PC = '0;
    BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    step();
    reset = 1'b0;
    push_rd("rst_prid", 5'd15, 32'h0000_1920);
    push_out("rst_req", OUT_REQ, 32'd0);
    push_out("rst_epc", OUT_EPC, 32'd0);
    push_rd("rst_sr", 5'd12, 32'd0);
    push_rd("rst_cause", 5'd13, 32'd0);
    drain();

    // Enabled interrupt
    mtc0(5'd12, 32'h0000_0401);
    push_rd("sr_wr", 5'd12, 32'h0000_0401);
    drain();
    HWInt = 6'b000001; PC = 32'h0000_3010; BDIn = 1'b0;
    push_out("int_req", OUT_REQ, 32'd1);
    drain();
    step();
    push_rd("int_sr", 5'd12, 32'h0000_0403);
    push_rd("int_cause", 5'd13, 32'h0000_0400);
    push_rd("int_epc", 5'd14, 32'h0000_3010);
    push_out("int_epcout", OUT_EPC, 32'h0000_3010);
    push_out("int_req_after", OUT_REQ, 32'd0);
    push_rd("unimpl_rd", 5'd16, 32'd0);
    drain();
    HWInt = '0;

    // Masking while EXL=1
    ExcCodeIn = 5'd5; PC = 32'h0000_3500;
    push_out("mask_req", OUT_REQ, 32'd0);
    drain();
    step();
    push_rd("mask_cause", 5'd13, 32'h0000_0000);
    push_rd("mask_epc", 5'd14, 32'h0000_3010);
    drain();
    ExcCodeIn = '0;
    eret();
    push_rd("eret_sr", 5'd12, 32'h0000_0401);
    drain();
    eret();
    push_rd("eret_idle_sr", 5'd12, 32'h0000_0401);
    drain();

    // Overflow in a delay slot
    ExcCodeIn = 5'd12; BDIn = 1'b1; PC = 32'h0000_3024;
    push_out("ov_req", OUT_REQ, 32'd1);
    drain();
    step();
    ExcCodeIn = '0; BDIn = 1'b0;
    push_rd("ov_epc", 5'd14, 32'h0000_3020);
    push_rd("ov_cause", 5'd13, 32'h8000_0030);
    push_rd("ov_sr", 5'd12, 32'h0000_0403);
    drain();
    eret();

    // Interrupt and exception together: interrupt wins
    HWInt = 6'b000001; ExcCodeIn = 5'd4; PC = 32'h0000_3100;
    push_out("both_req", OUT_REQ, 32'd1);
    drain();
    step();
    push_rd("both_cause", 5'd13, 32'h0000_0400);
    push_rd("both_epc", 5'd14, 32'h0000_3100);
    drain();
    HWInt = '0; ExcCodeIn = '0;
    eret();

    // mtc0 corner cases
    mtc0(5'd14, 32'h0000_3007);
    push_rd("mtc0_epc", 5'd14, 32'h0000_3004);
    push_out("mtc0_epcout", OUT_EPC, 32'h0000_3004);
    drain();
    mtc0(5'd13, 32'hFFFF_FFFF);
    push_rd("mtc0_cause", 5'd13, 32'h0000_0000);
    drain();
    mtc0(5'd3, 32'hFFFF_FFFF);
    push_rd("mtc0_unimpl", 5'd3, 32'h0000_0000);
    push_rd("mtc0_unimpl_sr", 5'd12, 32'h0000_0401);
    drain();

    ExcCodeIn = 5'd10; PC = 32'h0000_3202;
    A2 = 5'd12; DIn = 32'h0000_FC00; WE = 1'b1;
    push_out("mtc0_req", OUT_REQ, 32'd1);
    drain();
    step();
    ExcCodeIn = '0;
    push_rd("mtc0_drop_sr", 5'd12, 32'h0000_0403);
    push_rd("mtc0_drop_cause", 5'd13, 32'h0000_0028);
    push_rd("mtc0_drop_epc", 5'd14, 32'h0000_3200);
    drain();
    eret();

    // PC=0 in a delay slot wraps
    ExcCodeIn = 5'd4; BDIn = 1'b1; PC = 32'h0000_0000;
    step();
    ExcCodeIn = '0; BDIn = 1'b0;
    push_rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    push_rd("wrap_cause", 5'd13, 32'h8000_0010);
    drain();
    eret();

    // Reset wins over a simultaneous request
    ExcCodeIn = 5'd5; PC = 32'h0000_4000; reset = 1'b1;
    push_out("rstreq_req", OUT_REQ, 32'd1);
    drain();
    step();
    reset = 1'b0; ExcCodeIn = '0;
    push_rd("rstreq_sr", 5'd12, 32'd0);
    push_rd("rstreq_cause", 5'd13, 32'd0);
    push_out("rstreq_epc", OUT_EPC, 32'd0);
    push_rd("rstreq_prid", 5'd15, 32'h0000_1920);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
